// File: rtl/shift_out_tx_pkg.sv
// shift_out_tx_pkg: board clock default and phase-length helper for the serial shift-out transmitter.
package shift_out_tx_pkg;

    localparam int BOARD_MAIN_CLOCK_FREQ = 50_000_000;

    // Clock cycles per serial-clock half period; integer division truncates.
    function automatic int half_period(input int main_hz, input int shift_hz);
        return main_hz / (2 * shift_hz);
    endfunction

endpackage

// File: rtl/shift_out_tx_if.sv
// shift_out_tx_if: word handshake plus serial-in/parallel-out register lines.
interface shift_out_tx_if #(parameter int WIDTH = 8);

    logic [WIDTH-1:0] DATA_IN;
    logic             DATA_VALID_IN;
    logic             DATA_READY_OUT;
    logic             DONE_OUT;
    logic             SCLK_OUT;
    logic             SDATA_OUT;
    logic             LATCH_OUT;

    modport master (
        output DATA_IN, DATA_VALID_IN,
        input  DATA_READY_OUT, DONE_OUT, SCLK_OUT, SDATA_OUT, LATCH_OUT
    );

    modport slave (
        input  DATA_IN, DATA_VALID_IN,
        output DATA_READY_OUT, DONE_OUT, SCLK_OUT, SDATA_OUT, LATCH_OUT
    );

endinterface

// File: rtl/shift_out_tx_tick_div.sv
// tick_div: loadable down-counter; tc is high while the count sits at zero.
module tick_div #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] reload_val,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? reload_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/shift_out_tx.sv
// shift_out_tx: serialises a parallel word onto SCLK/SDATA and pulses LATCH for an
// external shift register; every phase lasts H = MAIN_CLOCK_FREQ/(2*SHIFT_FREQ) cycles.
module shift_out_tx
    import shift_out_tx_pkg::*;
#(
    parameter int MAIN_CLOCK_FREQ = BOARD_MAIN_CLOCK_FREQ,
    parameter int SHIFT_FREQ      = 1_000_000,
    parameter int WIDTH           = 8,
    parameter bit MSB_FIRST       = 1
) (
    input logic           CLK_IN,
    input logic           RST_IN,
    shift_out_tx_if.slave bus
);

    localparam int H  = half_period(MAIN_CLOCK_FREQ, SHIFT_FREQ);
    localparam int DW = (H > 1) ? $clog2(H) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DW-1:0] RELOAD = DW'(H - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOW   = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOW   = ST_LOW,
        HIGH  = ST_HIGH,
        LATCH = ST_LATCH
    } state_t;

    if (H < 1) begin : g_bad_h
        $error("shift_out_tx: MAIN_CLOCK_FREQ/(2*SHIFT_FREQ) must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, rot;
    logic [CW-1:0]    bit_q, bit_d;
    logic             sdata_q, sdata_d;
    logic             sclk_q, sclk_d;
    logic             latch_q, latch_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             load, tc;

    tick_div #(.W(DW)) u_tick_div (
        .clk        (CLK_IN),
        .rst        (RST_IN),
        .load       (load),
        .reload_val (RELOAD),
        .tc         (tc)
    );

    // Rotating keeps the outgoing bit at a fixed end of the register.
    assign rot = MSB_FIRST ? ((shreg_q << 1) | (shreg_q >> (WIDTH - 1)))
                           : ((shreg_q >> 1) | (shreg_q << (WIDTH - 1)));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        load    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.DATA_VALID_IN) begin
                state_d = LOW;
                load    = 1'b1;
                shreg_d = bus.DATA_IN;
                bit_d   = CW'(WIDTH - 1);
            end
            LOW: if (tc) begin
                state_d = HIGH;
                load    = 1'b1;
            end
            HIGH: if (tc) begin
                load = 1'b1;
                if (bit_q != '0) begin
                    state_d = LOW;
                    shreg_d = rot;
                    bit_d   = bit_q - 1'b1;
                end else begin
                    state_d = LATCH;
                end
            end
            LATCH: if (tc) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        sdata_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        sclk_d  = (state_d == HIGH);
        latch_d = (state_d == LATCH);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            sdata_q <= 1'b0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            sdata_q <= sdata_d;
            sclk_q  <= sclk_d;
            latch_q <= latch_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign bus.DATA_READY_OUT = ready_q;
    assign bus.DONE_OUT       = done_q;
    assign bus.SCLK_OUT       = sclk_q;
    assign bus.SDATA_OUT      = sdata_q;
    assign bus.LATCH_OUT      = latch_q;

endmodule

// File: tb/tb_shift_out_tx.sv
// tb_shift_out_tx: runs an MSB-first and an LSB-first instance in lockstep and checks
// the serial stream, phase timing and handshake against a word-level model.
module tb_shift_out_tx;

    localparam int MCF  = 16;
    localparam int SF   = 4;
    localparam int W    = 8;
    localparam int H    = MCF / (2 * SF);
    localparam int BUSY = (2 * W + 1) * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] data;
    logic valid;
    int vectors = 0;
    int errors  = 0;

    shift_out_tx_if #(.WIDTH(W)) bus_m ();
    shift_out_tx_if #(.WIDTH(W)) bus_l ();

    shift_out_tx #(.MAIN_CLOCK_FREQ(MCF), .SHIFT_FREQ(SF), .WIDTH(W), .MSB_FIRST(1)) dut_m (
        .CLK_IN (clk),
        .RST_IN (rst),
        .bus    (bus_m.slave)
    );

    shift_out_tx #(.MAIN_CLOCK_FREQ(MCF), .SHIFT_FREQ(SF), .WIDTH(W), .MSB_FIRST(0)) dut_l (
        .CLK_IN (clk),
        .RST_IN (rst),
        .bus    (bus_l.slave)
    );

    assign bus_m.DATA_IN       = data;
    assign bus_m.DATA_VALID_IN = valid;
    assign bus_l.DATA_IN       = data;
    assign bus_l.DATA_VALID_IN = valid;

    logic sclk [2], sdata [2], latch [2], ready [2], done [2];
    assign sclk[0]  = bus_m.SCLK_OUT;
    assign sclk[1]  = bus_l.SCLK_OUT;
    assign sdata[0] = bus_m.SDATA_OUT;
    assign sdata[1] = bus_l.SDATA_OUT;
    assign latch[0] = bus_m.LATCH_OUT;
    assign latch[1] = bus_l.LATCH_OUT;
    assign ready[0] = bus_m.DATA_READY_OUT;
    assign ready[1] = bus_l.DATA_READY_OUT;
    assign done[0]  = bus_m.DONE_OUT;
    assign done[1]  = bus_l.DONE_OUT;

    always #5 clk = ~clk;

    logic [W-1:0] seq [2];
    int nbits [2], rdy_low [2], latch_cnt [2], done_cnt [2];
    logic prev_sclk [2];

    // Wire order of a word, first transmitted bit in the MSB position.
    function automatic logic [W-1:0] wire_order(input int k, input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[W-1-i] = w[i];
        return (k == 0) ? w : r;
    endfunction

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            seq[k] = '0;
            nbits[k] = 0;
            rdy_low[k] = 0;
            latch_cnt[k] = 0;
            done_cnt[k] = 0;
            prev_sclk[k] = sclk[k];
        end
    endtask

    task automatic sample();
        for (int k = 0; k < 2; k++) begin
            if (sclk[k] && !prev_sclk[k]) begin
                seq[k] = {seq[k][W-2:0], sdata[k]};
                nbits[k]++;
            end
            prev_sclk[k] = sclk[k];
            if (!ready[k]) rdy_low[k]++;
            if (latch[k]) latch_cnt[k]++;
            if (done[k]) done_cnt[k]++;
        end
    endtask

    task automatic watch(input int maxc);
        for (int c = 0; c < maxc; c++) begin
            sample();
            if (done_cnt[0] > 0 && done_cnt[1] > 0) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({ready[k], done[k], sclk[k], sdata[k], latch[k]} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_held dut%0d: got %b expected 10000", k, {ready[k], done[k], sclk[k], sdata[k], latch[k]});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({ready[k], done[k], sclk[k], sdata[k], latch[k]} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_released dut%0d: got %b expected 10000", k, {ready[k], done[k], sclk[k], sdata[k], latch[k]});
            end
        end
    endtask

    task automatic test_idle();
        int bad [2];
        bad[0] = 0;
        bad[1] = 0;
        repeat (100) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                if ({sclk[k], sdata[k], latch[k], ready[k]} !== 4'b0001) bad[k]++;
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (bad[k] !== 0) begin
                errors++;
                $display("FAIL idle_quiet dut%0d: got %0d bad cycles expected 0", k, bad[k]);
            end
        end
    endtask

    task automatic test_transfer(input logic [W-1:0] w, input string name);
        clear_stats();
        data = w;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        data = ~w;
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] e;
            e = wire_order(k, w);
            vectors++;
            if (sdata[k] !== e[W-1] || sclk[k] !== 1'b0) begin
                errors++;
                $display("FAIL %s_first_bit dut%0d: got sdata=%b sclk=%b expected sdata=%b sclk=0", name, k, sdata[k], sclk[k], e[W-1]);
            end
        end
        watch(BUSY + 10);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (seq[k] !== wire_order(k, w)) begin
                errors++;
                $display("FAIL %s_bits dut%0d: got %h expected %h", name, k, seq[k], wire_order(k, w));
            end
            vectors++;
            if (nbits[k] !== W) begin
                errors++;
                $display("FAIL %s_sclk_pulses dut%0d: got %0d expected %0d", name, k, nbits[k], W);
            end
            vectors++;
            if (latch_cnt[k] !== H) begin
                errors++;
                $display("FAIL %s_latch_len dut%0d: got %0d expected %0d", name, k, latch_cnt[k], H);
            end
            vectors++;
            if (rdy_low[k] !== BUSY) begin
                errors++;
                $display("FAIL %s_busy_len dut%0d: got %0d expected %0d", name, k, rdy_low[k], BUSY);
            end
            vectors++;
            if (done_cnt[k] !== 1) begin
                errors++;
                $display("FAIL %s_done dut%0d: got %0d expected 1", name, k, done_cnt[k]);
            end
        end
    endtask

    task automatic test_random();
        repeat (6) test_transfer(W'($urandom_range(0, 255)), "rand");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1;
        w1 = W'($urandom_range(0, 255));
        if (w1 == 8'h3C) w1 = 8'h5A;
        clear_stats();
        data = w1;
        valid = 1'b1;
        @(negedge clk);
        watch(10);
        data = 8'h3C;
        watch(BUSY);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (seq[k] !== wire_order(k, w1) || done_cnt[k] !== 1) begin
                errors++;
                $display("FAIL b2b_first dut%0d: got %h done=%0d expected %h done=1", k, seq[k], done_cnt[k], wire_order(k, w1));
            end
            vectors++;
            if (ready[k] !== 1'b1 || done[k] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_done_ready dut%0d: got ready=%b done=%b expected 1 1", k, ready[k], done[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] e;
            e = wire_order(k, 8'h3C);
            vectors++;
            if (ready[k] !== 1'b0 || sdata[k] !== e[W-1]) begin
                errors++;
                $display("FAIL b2b_accept dut%0d: got ready=%b sdata=%b expected ready=0 sdata=%b", k, ready[k], sdata[k], e[W-1]);
            end
        end
        clear_stats();
        valid = 1'b0;
        watch(BUSY + 10);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (seq[k] !== wire_order(k, 8'h3C)) begin
                errors++;
                $display("FAIL b2b_second dut%0d: got %h expected %h", k, seq[k], wire_order(k, 8'h3C));
            end
            vectors++;
            if (rdy_low[k] !== BUSY || done_cnt[k] !== 1) begin
                errors++;
                $display("FAIL b2b_second_timing dut%0d: got busy=%0d done=%0d expected %0d 1", k, rdy_low[k], done_cnt[k], BUSY);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        data = 8'hFF;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({ready[k], done[k], sclk[k], sdata[k], latch[k]} !== 5'b10000) begin
                errors++;
                $display("FAIL reset_mid_immediate dut%0d: got %b expected 10000", k, {ready[k], done[k], sclk[k], sdata[k], latch[k]});
            end
        end
        clear_stats();
        repeat (3) begin
            @(negedge clk);
            sample();
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (latch_cnt[k] !== 0 || done_cnt[k] !== 0) begin
                errors++;
                $display("FAIL reset_mid_abandon dut%0d: got latch=%0d done=%0d expected 0 0", k, latch_cnt[k], done_cnt[k]);
            end
        end
        rst = 1'b0;
        test_transfer(W'($urandom_range(0, 255)), "after_reset");
    endtask

    initial begin
        data = '0;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_idle();
        test_transfer(8'hA5, "a5");
        test_transfer(8'h01, "x01");
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_out_tx.md
SHIFT_OUT_TX -- requirements
Module: shift_out_tx

Interface
REQ-001 The block SHALL have parameter MAIN_CLOCK_FREQ, default from the shared board include, giving the CLK_IN frequency in Hz.
REQ-002 The block SHALL have parameter SHIFT_FREQ, default 1_000_000, giving the serial clock frequency in Hz.
REQ-003 The block SHALL have parameter WIDTH, default 8, giving the number of bits per word.
REQ-004 The block SHALL have parameter MSB_FIRST, default 1, selecting MSB-first (1) or LSB-first (0) shift order.
REQ-005 The block SHALL have port CLK_IN, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port RST_IN, input, 1, reset, asynchronous and active-high.
REQ-007 The block SHALL have port DATA_IN, input, WIDTH, the parallel word to transmit.
REQ-008 The block SHALL have port DATA_VALID_IN, input, 1, set high when DATA_IN holds a word to send.
REQ-009 The block SHALL have port DATA_READY_OUT, output, 1, set high when a word can be accepted.
REQ-010 The block SHALL have port DONE_OUT, output, 1, a one-cycle pulse when a transfer completes.
REQ-011 The block SHALL have ports SCLK_OUT, SDATA_OUT and LATCH_OUT, each output, 1, the serial clock, data and storage-latch lines of an external serial-in/parallel-out register.

Function
REQ-012 H SHALL equal MAIN_CLOCK_FREQ/(2*SHIFT_FREQ), computed with integer division; an H below 1 SHALL be rejected at elaboration.
REQ-013 A word SHALL be accepted on a rising edge only when DATA_VALID_IN and DATA_READY_OUT are both 1; DATA_IN SHALL be captured on that edge and later changes SHALL be ignored.
REQ-014 The block SHALL use the states IDLE, LOW, HIGH and LATCH; IDLE->LOW on accept; LOW->HIGH after H cycles; HIGH->LOW after H cycles if bits remain, else HIGH->LATCH; LATCH->IDLE after H cycles.
REQ-015 In LOW, SCLK_OUT SHALL be 0 and SDATA_OUT SHALL hold the current bit; in HIGH, SCLK_OUT SHALL be 1 with SDATA_OUT unchanged; in LATCH, SCLK_OUT SHALL be 0 and LATCH_OUT SHALL be 1; LATCH_OUT SHALL be 0 in all other states.
REQ-016 All outputs SHALL be registered; the first bit SHALL appear on SDATA_OUT in the cycle after the accept edge.
REQ-017 The phase divider SHALL reload to H-1 on accept and on every phase change, so each phase lasts exactly H cycles and each transfer keeps DATA_READY_OUT low for exactly (2*WIDTH+1)*H cycles.
REQ-018 DATA_READY_OUT SHALL be 1 only in IDLE; DATA_VALID_IN while busy SHALL be ignored and SHALL not be queued.
REQ-019 DONE_OUT SHALL pulse for one cycle, on the first IDLE cycle after LATCH.
REQ-020 For back-to-back transfers with DATA_VALID_IN held high, the next accept SHALL occur on the first IDLE cycle, which is the same cycle in which DONE_OUT is high.
REQ-021 The bit counter SHALL count WIDTH bits without wrap; no bit SHALL be repeated or dropped.

Reset
REQ-022 Asserting RST_IN SHALL immediately force IDLE, DATA_READY_OUT=1, DONE_OUT=0, SCLK_OUT=0, SDATA_OUT=0, LATCH_OUT=0, and clear the divider and bit counter.
REQ-023 Reset during a transfer SHALL abandon the transfer without asserting LATCH_OUT or DONE_OUT.
REQ-024 After RST_IN is released, the first accept SHALL be possible on the first rising edge.

Structure
REQ-025 MAIN_CLOCK_FREQ SHALL come from the shared board include file, and the state encodings SHALL be localparams in the block.
REQ-026 The phase divider SHALL be a sub-module named tick_div, with load, reload value and terminal-count output.

Verification (MAIN_CLOCK_FREQ=16, SHIFT_FREQ=4, so H=2; WIDTH=8)
REQ-027 Sending 0xA5 with MSB_FIRST=1 SHALL give SDATA_OUT 1,0,1,0,0,1,0,1 sampled on SCLK_OUT rising edges, with 8 SCLK_OUT pulses, a 2-cycle LATCH_OUT pulse, and DATA_READY_OUT low for 34 cycles.
REQ-028 Sending 0x01 with MSB_FIRST=0 SHALL give a first bit of 1 followed by seven 0 bits.
REQ-029 With DATA_VALID_IN held high and the word changed to 0x3C mid-transfer, the current word SHALL be unaffected and 0x3C SHALL be sent next, accepted in the DONE_OUT cycle.
REQ-030 Asserting RST_IN at cycle 10 of a transfer SHALL give all outputs their reset values at once, with no LATCH_OUT or DONE_OUT, and a new word SHALL then transmit correctly.
REQ-031 With DATA_VALID_IN low after reset, SCLK_OUT, SDATA_OUT and LATCH_OUT SHALL stay 0 and DATA_READY_OUT SHALL stay 1 for 100 cycles.
